// File: rtl/id_hazard_unit.sv
// Decode-stage forwarding and load-use interlock: tracks EX/MEM/WB destination tags and
// resolves rs1/rs2 of the ID instruction. Define ID_BYPASS_EN to enable forwarding.
module id_hazard_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  instr,
  input  logic             id_valid,
  input  logic             flush,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } id_fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } tag_t;

  typedef struct packed {
    logic        stall;
    id_fwd_sel_t sel;
  } src_res_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2, rd;
  logic       uses_rs1, uses_rs2, writes_rd;
  tag_t       id_tag, ex_q, mem_q, wb_q;
  src_res_t   res1, res2;
  logic       unused_bits;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Function/immediate fields and the WB load flag play no part in hazard resolution.
  assign unused_bits = ^{instr[XLEN-1:25], instr[14:12], wb_q.is_load};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: writes_rd = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_BRANCH, OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign id_tag = '{valid: writes_rd && (rd != 5'd0), rd: rd, is_load: opcode == OPC_LOAD};

  function automatic src_res_t resolve(input logic used, input logic [4:0] rs,
                                       input tag_t ex, input tag_t mem, input tag_t wb);
    src_res_t r;
    r.stall = 1'b0;
    r.sel   = FWD_RF;
    if (used && rs != 5'd0) begin
`ifdef ID_BYPASS_EN
      // Youngest producer wins; a load only becomes forwardable once it reaches WB.
      if (ex.valid && ex.rd == rs) begin
        if (ex.is_load) r.stall = 1'b1;
        else            r.sel   = FWD_EX;
      end else if (mem.valid && mem.rd == rs) begin
        if (mem.is_load) r.stall = 1'b1;
        else             r.sel   = FWD_MEM;
      end else if (wb.valid && wb.rd == rs) begin
        r.sel = FWD_WB;
      end
`else
      r.stall = (ex.valid && ex.rd == rs) || (mem.valid && mem.rd == rs) ||
                (wb.valid && wb.rd == rs);
`endif
    end
    return r;
  endfunction

  assign res1    = resolve(uses_rs1, rs1, ex_q, mem_q, wb_q);
  assign res2    = resolve(uses_rs2, rs2, ex_q, mem_q, wb_q);
  assign stall   = id_valid && (res1.stall || res2.stall);
  assign fwd_rs1 = stall ? FWD_RF : res1.sel;
  assign fwd_rs2 = stall ? FWD_RF : res2.sel;

  // NOTE: sequential state uses non-blocking assignments so the shift reads pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (flush) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (id_valid && !stall) ? id_tag : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && stall_count != '1) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_hazard_unit.sv
// Self-checking bench for id_hazard_unit: directed vector table, hand-written reset/flush
// sequences, and a randomized run against an age-indexed reference model.
module tb_id_hazard_unit;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        id_valid = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic        stall;
  logic [31:0] stall_count;
  logic [1:0]  s_fwd1, s_fwd2;
  logic        s_stall;
  logic [1:0]  s_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_hazard_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .id_valid(id_valid), .flush(flush),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall(stall), .stall_count(stall_count)
  );

  id_hazard_unit #(.XLEN(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .instr(instr), .id_valid(id_valid), .flush(flush),
    .fwd_rs1(s_fwd1), .fwd_rs2(s_fwd2), .stall(s_stall), .stall_count(s_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction encoders
  function automatic logic [31:0] i_type(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, 3'b010, rd, op};
  endfunction

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, OP_OP};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, 5'b0, OP_BR};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        valid;
    logic        flush;
    logic        exp_stall;
    logic [1:0]  exp_f1;
    logic [1:0]  exp_f2;
    int          exp_cnt;
  } vec_t;

  function automatic vec_t row(input logic [31:0] i, input logic v, input logic f,
                               input logic s, input logic [1:0] f1, input logic [1:0] f2,
                               input int c);
    vec_t r;
    r.instr = i; r.valid = v; r.flush = f;
    r.exp_stall = s; r.exp_f1 = f1; r.exp_f2 = f2; r.exp_cnt = c;
    return r;
  endfunction

  // Reference model: in-flight producers indexed by age (0 = one instruction ahead of ID).
  logic       m_vld[3];
  logic [4:0] m_rd[3];
  logic       m_ld[3];
  int         m_cnt;

  task automatic m_decode(input logic [31:0] i, output logic u1, output logic u2,
                          output logic wr, output logic ld);
    logic [6:0] op;
    op = i[6:0];
    u1 = op inside {OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP};
    u2 = op inside {OP_BR, OP_ST, OP_OP};
    wr = (op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LD, OP_IMM, OP_OP}) && (i[11:7] != 5'd0);
    ld = (op == OP_LD);
  endtask

  task automatic m_resolve(input logic used, input logic [4:0] rs,
                           output logic hz, output logic [1:0] sel);
    hz  = 1'b0;
    sel = 2'd0;
    if (used && rs != 5'd0) begin
      for (int a = 0; a < 3; a++) begin
        if (m_vld[a] && m_rd[a] == rs) begin
`ifdef ID_BYPASS_EN
          // load data exists only from WB (age 2); ALU data from the cycle after issue
          if (m_ld[a] && a < 2) hz = 1'b1;
          else                  sel = 2'(a + 1);
`else
          hz = 1'b1;
`endif
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[10];
    logic [31:0] r;
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BR, OP_LD, OP_ST, OP_IMM, OP_OP, 7'b0001111};
    r = $urandom;
    r[6:0]   = ops[$urandom_range(9)];
    r[11:7]  = 5'($urandom_range(3));
    r[19:15] = 5'($urandom_range(3));
    r[24:20] = 5'($urandom_range(3));
    return r;
  endfunction

  vec_t        vecs[$];
  logic [31:0] nop;
  logic [31:0] cur_i;
  logic        cur_v, cur_f, held;
  logic        u1, u2, wr, ld, h1, h2, e_stall;
  logic [1:0]  sel1, sel2;

  initial begin
    nop = i_type(OP_IMM, 5'd0, 5'd0, 12'd0);
`ifdef ID_BYPASS_EN
    vecs.push_back(row(i_type(OP_IMM, 5'd5, 5'd0, 12'd1), 1, 0, 0, 0, 0, 0));
    vecs.push_back(row(r_type(7'h00, 5'd6, 5'd5, 5'd5),   1, 0, 0, 1, 1, 0));
    vecs.push_back(row(i_type(OP_LD, 5'd7, 5'd1, 12'd0),  1, 0, 0, 0, 0, 0));
    vecs.push_back(row(beq(5'd7, 5'd0),                   1, 0, 1, 0, 0, 0));
    vecs.push_back(row(beq(5'd7, 5'd0),                   1, 0, 1, 0, 0, 1));
    vecs.push_back(row(beq(5'd7, 5'd0),                   1, 0, 0, 3, 0, 2));
    vecs.push_back(row(i_type(OP_IMM, 5'd3, 5'd0, 12'd1), 1, 0, 0, 0, 0, 2));
    vecs.push_back(row(i_type(OP_IMM, 5'd3, 5'd3, 12'd2), 1, 0, 0, 1, 0, 2));
    vecs.push_back(row(r_type(7'h20, 5'd4, 5'd3, 5'd3),   1, 0, 0, 1, 1, 2));
    vecs.push_back(row(i_type(OP_IMM, 5'd0, 5'd0, 12'd5), 1, 0, 0, 0, 0, 2));
    vecs.push_back(row(r_type(7'h00, 5'd1, 5'd0, 5'd0),   1, 0, 0, 0, 0, 2));
    vecs.push_back(row(i_type(OP_LD, 5'd9, 5'd2, 12'd0),  1, 0, 0, 0, 0, 2));
    vecs.push_back(row(nop,                               1, 0, 0, 0, 0, 2));
    vecs.push_back(row(r_type(7'h00, 5'd11, 5'd9, 5'd0),  1, 0, 1, 0, 0, 2));
    vecs.push_back(row(r_type(7'h00, 5'd11, 5'd9, 5'd0),  1, 0, 0, 3, 0, 3));
    vecs.push_back(row(i_type(OP_LD, 5'd12, 5'd0, 12'd0), 1, 0, 0, 0, 0, 3));
    vecs.push_back(row(r_type(7'h00, 5'd13, 5'd12, 5'd12), 1, 1, 1, 0, 0, 3));
    vecs.push_back(row(r_type(7'h00, 5'd13, 5'd12, 5'd12), 1, 0, 0, 0, 0, 4));
    vecs.push_back(row(i_type(OP_IMM, 5'd14, 5'd0, 12'd1), 0, 0, 0, 0, 0, 4));
    vecs.push_back(row(r_type(7'h00, 5'd15, 5'd14, 5'd0), 1, 0, 0, 0, 0, 4));
    vecs.push_back(row(r_type(7'h00, 5'd16, 5'd15, 5'd0), 1, 0, 0, 1, 0, 4));
`else
    vecs.push_back(row(i_type(OP_IMM, 5'd5, 5'd0, 12'd1), 1, 0, 0, 0, 0, 0));
    vecs.push_back(row(r_type(7'h00, 5'd6, 5'd5, 5'd0),   1, 0, 1, 0, 0, 0));
    vecs.push_back(row(r_type(7'h00, 5'd6, 5'd5, 5'd0),   1, 0, 1, 0, 0, 1));
    vecs.push_back(row(r_type(7'h00, 5'd6, 5'd5, 5'd0),   1, 0, 1, 0, 0, 2));
    vecs.push_back(row(r_type(7'h00, 5'd6, 5'd5, 5'd0),   1, 0, 0, 0, 0, 3));
    vecs.push_back(row(i_type(OP_LD, 5'd7, 5'd1, 12'd0),  1, 0, 0, 0, 0, 3));
    vecs.push_back(row(beq(5'd7, 5'd0),                   1, 0, 1, 0, 0, 3));
    vecs.push_back(row(beq(5'd7, 5'd0),                   1, 0, 1, 0, 0, 4));
    vecs.push_back(row(beq(5'd7, 5'd0),                   1, 0, 1, 0, 0, 5));
    vecs.push_back(row(beq(5'd7, 5'd0),                   1, 0, 0, 0, 0, 6));
    vecs.push_back(row(i_type(OP_IMM, 5'd0, 5'd0, 12'd5), 1, 0, 0, 0, 0, 6));
    vecs.push_back(row(r_type(7'h00, 5'd1, 5'd0, 5'd0),   1, 0, 0, 0, 0, 6));
    vecs.push_back(row(i_type(OP_LD, 5'd12, 5'd0, 12'd0), 1, 0, 0, 0, 0, 6));
    vecs.push_back(row(r_type(7'h00, 5'd13, 5'd12, 5'd12), 1, 1, 1, 0, 0, 6));
    vecs.push_back(row(r_type(7'h00, 5'd13, 5'd12, 5'd12), 1, 0, 0, 0, 0, 7));
    vecs.push_back(row(i_type(OP_IMM, 5'd14, 5'd0, 12'd1), 0, 0, 0, 0, 0, 7));
    vecs.push_back(row(r_type(7'h00, 5'd15, 5'd14, 5'd0), 1, 0, 0, 0, 0, 7));
    vecs.push_back(row(r_type(7'h20, 5'd4, 5'd15, 5'd15), 1, 0, 1, 0, 0, 7));
`endif

    // Reset state, with a valid instruction presented
    instr = r_type(7'h00, 5'd6, 5'd5, 5'd5);
    id_valid = 1'b1;
    #2;
    check("reset stall", 32'(stall), 32'd0);
    check("reset fwd_rs1", 32'(fwd_rs1), 32'd0);
    check("reset fwd_rs2", 32'(fwd_rs2), 32'd0);
    check("reset stall_count", stall_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      instr = vecs[k].instr; id_valid = vecs[k].valid; flush = vecs[k].flush;
      #1;
      check($sformatf("vec%0d stall", k), 32'(stall), 32'(vecs[k].exp_stall));
      check($sformatf("vec%0d fwd_rs1", k), 32'(fwd_rs1), 32'(vecs[k].exp_f1));
      check($sformatf("vec%0d fwd_rs2", k), 32'(fwd_rs2), 32'(vecs[k].exp_f2));
      check($sformatf("vec%0d stall_count", k), stall_count, 32'(vecs[k].exp_cnt));
      @(negedge clk);
    end

    // Reset asserted in the middle of a load-use stall
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    instr = i_type(OP_LD, 5'd1, 5'd2, 12'd0); id_valid = 1'b1;
    @(negedge clk);
    instr = r_type(7'h00, 5'd2, 5'd1, 5'd0);
    #1;
    check("midrst stall before", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    check("midrst stall second", 32'(stall), 32'd1);
    check("midrst count before", stall_count, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst stall async", 32'(stall), 32'd0);
    check("midrst count async", stall_count, 32'd0);
    check("midrst fwd_rs1", 32'(fwd_rs1), 32'd0);
    @(negedge clk);
    check("midrst count held", stall_count, 32'd0);
    for (int a = 0; a < 3; a++) begin
      m_vld[a] = 1'b0; m_rd[a] = 5'd0; m_ld[a] = 1'b0;
    end
    m_cnt = 0;
    held  = 1'b0;
    cur_i = nop;
    cur_v = 1'b0;
    rst_n = 1'b1;

    // Randomized run against the reference model
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!held) begin
        cur_i = rand_instr();
        cur_v = ($urandom_range(9) != 0);
      end
      cur_f = ($urandom_range(24) == 0);
      instr = cur_i; id_valid = cur_v; flush = cur_f;
      #1;
      m_decode(cur_i, u1, u2, wr, ld);
      m_resolve(u1, cur_i[19:15], h1, sel1);
      m_resolve(u2, cur_i[24:20], h2, sel2);
      e_stall = cur_v && (h1 || h2);
      if (e_stall) begin
        sel1 = 2'd0;
        sel2 = 2'd0;
      end
      check($sformatf("rnd%0d stall", cyc), 32'(stall), 32'(e_stall));
      check($sformatf("rnd%0d fwd_rs1", cyc), 32'(fwd_rs1), 32'(sel1));
      check($sformatf("rnd%0d fwd_rs2", cyc), 32'(fwd_rs2), 32'(sel2));
      check($sformatf("rnd%0d stall_count", cyc), stall_count, 32'(m_cnt));
      check($sformatf("rnd%0d sat_count", cyc), 32'(s_count), 32'((m_cnt > 3) ? 3 : m_cnt));
      if (cur_f) begin
        for (int a = 0; a < 3; a++) m_vld[a] = 1'b0;
      end else begin
        for (int a = 2; a > 0; a--) begin
          m_vld[a] = m_vld[a-1]; m_rd[a] = m_rd[a-1]; m_ld[a] = m_ld[a-1];
        end
        m_vld[0] = cur_v && !e_stall && wr;
        m_rd[0]  = cur_i[11:7];
        m_ld[0]  = ld;
      end
      if (e_stall) m_cnt++;
      held = e_stall;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/id_hazard_unit.md
# id_hazard_unit

Forwarding and interlock controller for the decode stage. Decodes the register sources of the instruction sitting in ID, tracks the destination register of every instruction in flight in EX, MEM and WB, and drives the forwarding selects (`fwd_rs1`, `fwd_rs2`) consumed by decode. Raises `stall` when a source cannot be forwarded in time; this holds IF/ID and injects a bubble into EX. Branch compare happens in ID, so every hazard is resolved against ID.

## Interface
Parameters:
- `XLEN`, 32, instruction width.
- `CNT_W`, 32, width of the stall-cycle counter.

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr`  in  XLEN  instruction currently in ID.
- `id_valid`  in  1  `instr` is a real instruction, not a bubble.
- `flush`  in  1  trap/redirect; kills all in-flight tags.
- `fwd_rs1`  out  2  rs1 select (id_fwd_sel_t): 0 = RF, 1 = EX, 2 = MEM, 3 = WB.
- `fwd_rs2`  out  2  rs2 select, same encoding.
- `stall`  out  1  hold PC and IF/ID; insert bubble into EX.
- `stall_count`  out  CNT_W  saturating count of stalled cycles.

## Operation
Source and destination decode, combinational on `instr`:
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM and OP.
- rs2 is used by BRANCH, STORE and OP.
- The instruction writes rd for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM and OP, only when rd != 0.
- `is_load` is set when opcode = LOAD.
- x0 never produces a hazard or a forward.

Tag pipeline:
- Three registered slots, EX, MEM and WB. Each holds {valid, rd[4:0], is_load}.
- Every cycle, MEM moves to WB and EX moves to MEM.
- EX loads the ID tag when `id_valid && !stall`; otherwise EX loads an invalid tag (bubble).
- `flush` clears all three slots to invalid on the next edge. It has priority over the shift.

Matching for each used source `rsN`, in priority order EX > MEM > WB (the youngest producer wins):
- EX slot, not a load: select EX.
- EX slot, load: stall. Data is not ready until WB.
- MEM slot, not a load: select MEM.
- MEM slot, load: stall.
- WB slot, any: select WB.
- No match: select RF.

Output rules:
- `stall` is the OR of both sources' stall conditions, gated by `id_valid`.
- While `stall` = 1, `fwd_rs1` and `fwd_rs2` are forced to RF.
- `stall_count` increments on each cycle with `stall` = 1 and saturates at all-ones.

## Timing
- `fwd_rs1`, `fwd_rs2` and `stall` are combinational from `instr`, `id_valid` and the registered slots. There is no added latency.
- Slots and `stall_count` update on the posedge of `clk`.
- Reset (asynchronous, `rst_n` = 0): all slots invalid and `stall_count` = 0. As a result `fwd_rs1` = `fwd_rs2` = RF and `stall` = 0 during reset and on the first cycle after it.
- Load-use:
  - Consumer directly behind a load: stalls 2 cycles (load in EX, then load in MEM), then forwards from WB.
  - Consumer one slot behind a load: stalls 1 cycle.
- ALU producer directly ahead: 0 stall cycles, select EX.
- A `flush` in the same cycle as a stall: slots clear. The stall is released on the next cycle unless a new hazard arises.
- Reset in mid-stall: `stall` drops asynchronously. The counter holds its reset value.

## Configuration
- `ID_BYPASS_EN` defined: forwarding as described above.
- `ID_BYPASS_EN` undefined:
  - `fwd_rs1` and `fwd_rs2` are tied to RF.
  - `stall` is asserted whenever any used source matches a valid EX, MEM or WB slot.
  - A dependent instruction therefore waits until its producer has left WB: 3 stall cycles when directly behind its producer.

## Test plan
- `addi x5,x0,1` then `add x6,x5,x5` → on the second instruction `fwd_rs1` = `fwd_rs2` = 1 (EX), `stall` = 0.
- `lw x7,0(x1)` then `beq x7,x0,L` → `stall` = 1 for 2 cycles, then `fwd_rs1` = 3 (WB); `stall_count` = 2.
- `addi x3,...`, `addi x3,...`, `sub x4,x3,x3` → select EX, not MEM (the younger producer wins).
- `addi x0,x0,5` then `add x1,x0,x0` → `fwd_rs1` = `fwd_rs2` = 0, `stall` = 0.
- Load in EX with a dependent instruction stalled, then `flush` = 1 for one cycle → the next cycle has `stall` = 0 and all slots are invalid.
- With `ID_BYPASS_EN` undefined: `addi x5,...` then `add x6,x5,x0` → `stall` for 3 cycles, then the instruction proceeds with RF selects.
